coherence_mem_responder: RTL and testbench
==========================================

# coherence_mem_responder

Memory-side endpoint of the snooping coherence protocol. It accepts ordered bus requests (`req_msg_t`: GETS/GETM/PUTM) and tracks a per-line `memory_state_t` and owner. It absorbs owner data sent to memory (`resp_msg_t` with `memory_flag`) and issues data/ack responses (`resp_msg_t`) back to requesting caches. It sits between the request bus and the response network and stands in for backing memory.

## Interface
- `MEM_LINES`, 16: number of 256-bit lines held; power of two.
- `RESP_LATENCY`, 2: cycles from request accept to `resp_o.valid`; must be ≥1.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_i` in `req_msg_t`: bus request; `valid` qualifies it.
- `req_ready_o` out 1: request accepted when `req_i.valid && req_ready_o`.
- `wb_i` in `resp_msg_t`: cache-to-memory data; considered only when `valid && memory_flag`.
- `resp_o` out `resp_msg_t`: response to requester; `memory_flag` is always 0.
- `resp_ready_i` in 1: response consumed when `resp_o.valid && resp_ready_i`.
- `err_o` out 1: one-cycle protocol-error pulse.

## Operation
- Line index is `addr[$clog2(MEM_LINES)+4:5]`. Upper address bits are ignored; aliasing is intended.
- Each table entry holds: state (`memory_state_t`), owner (source width), and data (256 b).
- Controller FSM states: MC_IDLE, MC_DELAY, MC_RESP, MC_WAIT_WB. `req_ready_o` = (state==MC_IDLE).
- Transitions on an accepted request (S = `source`):
  - MI+GETS: response EXCLUSIVE with line data; line → MEORM, owner=S.
  - MI+GETM: response DATA; line → MEORM, owner=S.
  - MS+GETS: response DATA; line stays MS.
  - MS+GETM: response DATA; line → MEORM, owner=S. Sharers self-invalidate by snooping.
  - MEORM+GETS: no response, because the owner supplies data. Line → MSD; FSM → MC_WAIT_WB.
  - MEORM+GETM: no response; owner=S; line stays MEORM; FSM → MC_IDLE next cycle.
  - MEORM+PUTM with S==owner: line → MID; FSM → MC_WAIT_WB.
  - PUTM with S≠owner, or with the line in MI/MS (stale): response NODATA to S; state unchanged.
- A response path carries `destination`=S, `addr`=request addr, and `data`=line data. For NODATA, `data`=0.
- In MC_WAIT_WB, the block accepts `wb_i` only when its index matches the pending line:
  - MSD: write `wb_i.data`; line → MS.
  - MID with `mmsg`=DATA: write data; line → MI.
  - MID with NODATAE: no write; line → MI.
  - After either, FSM → MC_IDLE.
- `err_o` pulses for any of the following:
  - a `wb_i` seen outside MC_WAIT_WB;
  - a `wb_i` with an index mismatch (it is ignored and the FSM keeps waiting);
  - a request that decodes a line in MEORMD. MEORMD is reserved and never entered.

## Timing
- Reset values:
  - FSM = MC_IDLE; `req_ready_o` = 0 during reset, 1 the cycle after.
  - `resp_o` = all-zero; `err_o` = 0.
  - All lines MI, owner 0, data 0.
- Accept cycle T: the table entry is read and updated at the T→T+1 edge.
- Response path: `resp_o.valid` rises at cycle T+RESP_LATENCY. A counter runs in MC_DELAY, then MC_RESP holds `resp_o` stable until `resp_ready_i`. After the handshake the FSM returns to MC_IDLE, so back-to-back accept spacing is ≥ RESP_LATENCY+1 cycles.
- For RESP_LATENCY=1, the FSM goes from T straight to MC_RESP.
- A `wb_i` arriving in cycle T itself is not yet eligible; acceptance starts at T+1 and takes 1 cycle.
- Reset mid-operation drops any pending response or wait and reinitialises the table.

## Configuration
- `MEM_EXCLUSIVE_EN` defined: MI+GETS grants EXCLUSIVE and the line → MEORM (MESI).
- `MEM_EXCLUSIVE_EN` undefined: MI+GETS responds DATA and the line → MS (MSI). EXCLUSIVE is never sent.

## Structure
- Add to `cache_types`:
  - `mem_ctrl_state_t` (MC_IDLE, MC_DELAY, MC_RESP, MC_WAIT_WB);
  - `mem_entry_t` (state, owner, data) as a packed struct.
- Sub-module `coherence_mem_table`: MEM_LINES × `mem_entry_t` storage with one read port and one write port, synchronous write, and reset-to-MI.

## Test plan
- Reset, then GETS src=2 addr=0x40 → at T+2 `resp_o`: dest=2, EXCLUSIVE (DATA if the macro is off), data=0; line 2 = MEORM, owner=2.
- Continue: GETS src=5 addr=0x40 → no response; line MSD. Then `wb_i` DATA 0xAA.. → line MS, data 0xAA..; next GETS src=1 returns 0xAA...
- Line MEORM, owner=3; PUTM src=3 → MID. Send `wb_i` NODATAE → line MI, data unchanged, no `err_o`.
- PUTM src=4 to a line owned by 3 → NODATA response to 4; line stays MEORM with owner 3.
- Hold `resp_ready_i`=0 for 5 cycles → `resp_o` stays stable and `req_ready_o`=0; release → MC_IDLE next cycle.
- `wb_i` sent while in MC_IDLE → `err_o` pulses 1 cycle, table unchanged. Assert `rst` during MC_WAIT_WB → the next cycle shows MC_IDLE and all lines MI.

Source files
------------

// File: rtl/coherence_mem_responder_pkg.sv
// +------------------------------------------------------------------------+
// | coherence_mem_responder_pkg                                            |
// | Shared message, line-state and controller types for the memory-side  |
// | endpoint of the snooping coherence protocol.                           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

package coherence_mem_responder_pkg;

  localparam int SRC_W  = 4;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    GETS = 2'd0,
    GETM = 2'd1,
    PUTM = 2'd2
  } req_type_t;

  typedef enum logic [1:0] {
    DATA      = 2'd0,
    EXCLUSIVE = 2'd1,
    NODATA    = 2'd2,
    NODATAE   = 2'd3
  } mmsg_t;

  // MEORMD is kept in the encoding for protocol compatibility but is never
  // entered by this block; seeing it on a line is treated as an error.
  typedef enum logic [2:0] {
    MI     = 3'd0,
    MS     = 3'd1,
    MEORM  = 3'd2,
    MEORMD = 3'd3,
    MSD    = 3'd4,
    MID    = 3'd5
  } memory_state_t;

  typedef struct packed {
    logic              valid;
    req_type_t         rtype;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] addr;
  } req_msg_t;

  typedef struct packed {
    logic              valid;
    logic              memory_flag;
    mmsg_t             mmsg;
    logic [SRC_W-1:0]  source;
    logic [SRC_W-1:0]  destination;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } resp_msg_t;

  typedef enum logic [1:0] {
    MC_IDLE    = 2'd0,
    MC_DELAY   = 2'd1,
    MC_RESP    = 2'd2,
    MC_WAIT_WB = 2'd3
  } mem_ctrl_state_t;

  typedef struct packed {
    memory_state_t     state;
    logic [SRC_W-1:0]  owner;
    logic [LINE_W-1:0] data;
  } mem_entry_t;

endpackage

`default_nettype wire

// File: rtl/coherence_mem_responder_if.sv
// +------------------------------------------------------------------------+
// | coherence_mem_responder_if                                             |
// | Request bus, writeback, response and error signals of the memory      |
// | responder. "slave" is the responder side, "master" the cache side.    |
// |   req_i / req_ready_o    : ordered bus request handshake              |
// |   wb_i                   : cache-to-memory data (memory_flag set)     |
// |   resp_o / resp_ready_i  : response to requesting cache               |
// |   err_o                  : one-cycle protocol-error pulse             |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

interface coherence_mem_responder_if;
  import coherence_mem_responder_pkg::*;

  req_msg_t  req_i;
  logic      req_ready_o;
  resp_msg_t wb_i;
  resp_msg_t resp_o;
  logic      resp_ready_i;
  logic      err_o;

  modport master (
    output req_i, wb_i, resp_ready_i,
    input  req_ready_o, resp_o, err_o
  );

  modport slave (
    input  req_i, wb_i, resp_ready_i,
    output req_ready_o, resp_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/coherence_mem_responder_table.sv
// +------------------------------------------------------------------------+
// | coherence_mem_table                                                    |
// | MEM_LINES x mem_entry_t line table: one asynchronous read port, one   |
// | synchronous write port; reset returns every line to MI/owner 0/data 0.|
// |   i_rd_idx / o_rd_entry  : read port                                  |
// |   i_wr_en/i_wr_idx/i_wr_entry : write port                            |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

module coherence_mem_table
  import coherence_mem_responder_pkg::*;
#(
  parameter int MEM_LINES = 16
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic [$clog2(MEM_LINES)-1:0] i_rd_idx,
  output mem_entry_t                        o_rd_entry,
  input  wire logic                         i_wr_en,
  input  wire logic [$clog2(MEM_LINES)-1:0] i_wr_idx,
  input  mem_entry_t                        i_wr_entry
);

  mem_entry_t r_mem [MEM_LINES];

  assign o_rd_entry = r_mem[i_rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LINES; i++) begin
        r_mem[i] <= '{state: MI, owner: '0, data: '0};
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_entry;
    end
  end

endmodule

`default_nettype wire

// File: rtl/coherence_mem_responder.sv
// +------------------------------------------------------------------------+
// | coherence_mem_responder                                                |
// | Memory-side endpoint of the snooping coherence protocol. Accepts      |
// | GETS/GETM/PUTM requests, tracks per-line memory state and owner,      |
// | absorbs owner writebacks and returns data/ack responses.              |
// |   clk, rst : clock, synchronous active-high reset                    |
// |   bus      : coherence_mem_responder_if.slave (req/wb/resp/err)      |
// | Build option: MEM_EXCLUSIVE_EN - MI+GETS grants EXCLUSIVE (MESI);     |
// |   when undefined MI+GETS returns DATA and the line becomes MS (MSI).  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

module coherence_mem_responder
  import coherence_mem_responder_pkg::*;
#(
  parameter int MEM_LINES    = 16,
  parameter int RESP_LATENCY = 2
) (
  input wire logic                  clk,
  input wire logic                  rst,
  coherence_mem_responder_if.slave  bus
);

  localparam int c_IDX_W = $clog2(MEM_LINES);
  localparam int c_CNT_W = $clog2(RESP_LATENCY + 1);

  mem_ctrl_state_t r_state, w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  resp_msg_t          r_resp;
  logic [c_IDX_W-1:0] r_pend_idx;
  logic               r_err;

  logic [c_IDX_W-1:0] w_req_idx, w_wb_idx, w_rd_idx;
  logic               w_accept, w_wb_seen, w_wb_match;
  mem_entry_t         w_rd_entry, w_wr_entry;
  logic               w_wr_en, w_respond, w_to_wait, w_err_req, w_err;
  mmsg_t              w_mmsg;
  logic [LINE_W-1:0]  w_resp_data;

  assign w_req_idx  = bus.req_i.addr[c_IDX_W+4:5];
  assign w_wb_idx   = bus.wb_i.addr[c_IDX_W+4:5];
  assign w_accept   = (r_state == MC_IDLE) && bus.req_i.valid && !rst;
  assign w_wb_seen  = bus.wb_i.valid && bus.wb_i.memory_flag;
  assign w_wb_match = (r_state == MC_WAIT_WB) && w_wb_seen && (w_wb_idx == r_pend_idx);
  // While waiting for a writeback the read port looks at the pending line.
  assign w_rd_idx   = (r_state == MC_WAIT_WB) ? r_pend_idx : w_req_idx;

  coherence_mem_table #(.MEM_LINES(MEM_LINES)) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_rd_idx),
    .o_rd_entry (w_rd_entry),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_rd_idx),
    .i_wr_entry (w_wr_entry)
  );

  // Protocol decode: table update and response selection for the accepted
  // request, or the writeback that completes a pending MSD/MID line.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_entry  = w_rd_entry;
    w_respond   = 1'b0;
    w_mmsg      = DATA;
    w_resp_data = w_rd_entry.data;
    w_to_wait   = 1'b0;
    w_err_req   = 1'b0;

    if (w_accept) begin
      case (w_rd_entry.state)
        MI: begin
          case (bus.req_i.rtype)
            GETS: begin
              w_respond = 1'b1;
              w_wr_en   = 1'b1;
`ifdef MEM_EXCLUSIVE_EN
              w_mmsg           = EXCLUSIVE;
              w_wr_entry.state = MEORM;
              w_wr_entry.owner = bus.req_i.source;
`else
              w_wr_entry.state = MS;
`endif
            end
            GETM: begin
              w_respond        = 1'b1;
              w_wr_en          = 1'b1;
              w_wr_entry.state = MEORM;
              w_wr_entry.owner = bus.req_i.source;
            end
            PUTM: begin
              w_respond   = 1'b1;
              w_mmsg      = NODATA;
              w_resp_data = '0;
            end
            default: ;
          endcase
        end
        MS: begin
          case (bus.req_i.rtype)
            GETS: w_respond = 1'b1;
            GETM: begin
              w_respond        = 1'b1;
              w_wr_en          = 1'b1;
              w_wr_entry.state = MEORM;
              w_wr_entry.owner = bus.req_i.source;
            end
            PUTM: begin
              w_respond   = 1'b1;
              w_mmsg      = NODATA;
              w_resp_data = '0;
            end
            default: ;
          endcase
        end
        MEORM: begin
          case (bus.req_i.rtype)
            // Owner forwards the data; memory waits for its copy.
            GETS: begin
              w_wr_en          = 1'b1;
              w_wr_entry.state = MSD;
              w_to_wait        = 1'b1;
            end
            GETM: begin
              w_wr_en          = 1'b1;
              w_wr_entry.owner = bus.req_i.source;
            end
            PUTM: begin
              if (bus.req_i.source == w_rd_entry.owner) begin
                w_wr_en          = 1'b1;
                w_wr_entry.state = MID;
                w_to_wait        = 1'b1;
              end else begin
                w_respond   = 1'b1;
                w_mmsg      = NODATA;
                w_resp_data = '0;
              end
            end
            default: ;
          endcase
        end
        MEORMD:  w_err_req = 1'b1;
        default: ;
      endcase
    end

    if (w_wb_match) begin
      case (w_rd_entry.state)
        MSD: begin
          w_wr_en          = 1'b1;
          w_wr_entry.state = MS;
          w_wr_entry.data  = bus.wb_i.data;
        end
        MID: begin
          w_wr_en          = 1'b1;
          w_wr_entry.state = MI;
          if (bus.wb_i.mmsg == DATA) begin
            w_wr_entry.data = bus.wb_i.data;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_err = w_err_req || (w_wb_seen && !w_wb_match);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MC_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Controller next state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MC_IDLE: begin
        if (w_respond) begin
          w_next_state = (RESP_LATENCY == 1) ? MC_RESP : MC_DELAY;
        end else if (w_to_wait) begin
          w_next_state = MC_WAIT_WB;
        end
      end
      MC_DELAY: begin
        if (r_cnt <= c_CNT_W'(1)) begin
          w_next_state = MC_RESP;
        end
      end
      MC_RESP: begin
        if (bus.resp_ready_i) begin
          w_next_state = MC_IDLE;
        end
      end
      MC_WAIT_WB: begin
        if (w_wb_match) begin
          w_next_state = MC_IDLE;
        end
      end
      default: w_next_state = MC_IDLE;
    endcase
  end

  // Response payload captured at accept time and held through MC_RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_resp     <= '0;
      r_pend_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_accept) begin
        r_cnt              <= c_CNT_W'(RESP_LATENCY - 1);
        r_pend_idx         <= w_req_idx;
        r_resp.valid       <= 1'b1;
        r_resp.memory_flag <= 1'b0;
        r_resp.mmsg        <= w_mmsg;
        r_resp.source      <= '0;
        r_resp.destination <= bus.req_i.source;
        r_resp.addr        <= bus.req_i.addr;
        r_resp.data        <= w_resp_data;
      end else if (r_state == MC_DELAY) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
    end
  end

  assign bus.req_ready_o = (r_state == MC_IDLE) && !rst;
  assign bus.resp_o      = (r_state == MC_RESP) ? r_resp : '0;
  assign bus.err_o       = r_err;

  // Address bits outside the line index and the writeback routing fields
  // carry no meaning for memory.
  logic w_unused;
  assign w_unused = &{1'b0, bus.req_i.addr[ADDR_W-1:c_IDX_W+5], bus.req_i.addr[4:0],
                      bus.wb_i.addr[ADDR_W-1:c_IDX_W+5], bus.wb_i.addr[4:0],
                      bus.wb_i.source, bus.wb_i.destination};

endmodule

`default_nettype wire

// File: tb/tb_coherence_mem_responder.sv
// +------------------------------------------------------------------------+
// | tb_coherence_mem_responder                                             |
// | Directed self-checking bench for coherence_mem_responder with a       |
// | response scoreboard.                                                   |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_coherence_mem_responder;
  import coherence_mem_responder_pkg::*;

  localparam int MEM_LINES    = 16;
  localparam int RESP_LATENCY = 2;
  localparam int CW           = 320;
  localparam logic [LINE_W-1:0] c_AA = {32{8'hAA}};
  localparam logic [LINE_W-1:0] c_55 = {32{8'h55}};

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  coherence_mem_responder_if bus_if();

  coherence_mem_responder #(
    .MEM_LINES    (MEM_LINES),
    .RESP_LATENCY (RESP_LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [SRC_W-1:0]  dest;
    logic [ADDR_W-1:0] addr;
    mmsg_t             mmsg;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [SRC_W-1:0] dest, input logic [ADDR_W-1:0] addr,
                          input mmsg_t mmsg, input logic [LINE_W-1:0] data);
    exp_t e;
    e.dest = dest; e.addr = addr; e.mmsg = mmsg; e.data = data;
    sb.push_back(e);
  endtask

  // Drives one request for one cycle; returns at the falling edge of T+1.
  task automatic send_req(input req_type_t t, input logic [SRC_W-1:0] src,
                          input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    chk("req_ready_before_req", bus_if.req_ready_o, 1);
    bus_if.req_i = '{valid: 1'b1, rtype: t, source: src, addr: addr};
    @(negedge clk);
    bus_if.req_i = '0;
  endtask

  // Waits (bounded) for resp_o.valid, checks latency and pops the scoreboard.
  task automatic wait_resp(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (bus_if.resp_o.valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, RESP_LATENCY);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_dest"},  bus_if.resp_o.destination, e.dest);
      chk({tag, "_addr"},  bus_if.resp_o.addr,        e.addr);
      chk({tag, "_mmsg"},  bus_if.resp_o.mmsg,        e.mmsg);
      chk({tag, "_data"},  bus_if.resp_o.data,        e.data);
      chk({tag, "_mflag"}, bus_if.resp_o.memory_flag, 0);
    end
  endtask

  // With resp_ready_i high the handshake completes and the FSM idles again.
  task automatic after_resp(input string tag);
    @(negedge clk);
    chk({tag, "_valid_drop"}, bus_if.resp_o.valid, 0);
    chk({tag, "_idle_again"}, bus_if.req_ready_o, 1);
  endtask

  task automatic send_wb(input mmsg_t m, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] d);
    bus_if.wb_i = '{valid: 1'b1, memory_flag: 1'b1, mmsg: m, source: 4'd0,
                    destination: 4'd0, addr: addr, data: d};
    @(negedge clk);
    bus_if.wb_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int dirty;
    rst = 1'b1;
    bus_if.req_i = '0;
    bus_if.wb_i = '0;
    bus_if.resp_ready_i = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus_if.req_ready_o, 0);
    chk("rst_resp",      bus_if.resp_o, '0);
    chk("rst_err",       bus_if.err_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", bus_if.req_ready_o, 1);
    chk("post_rst_line2_state", dut.u_table.r_mem[2].state, MI);

    // GETS to an MI line
`ifdef MEM_EXCLUSIVE_EN
    push_exp(4'd2, 32'h40, EXCLUSIVE, '0);
`else
    push_exp(4'd2, 32'h40, DATA, '0);
`endif
    send_req(GETS, 4'd2, 32'h40);
    wait_resp("gets_mi");
    after_resp("gets_mi");
`ifdef MEM_EXCLUSIVE_EN
    chk("gets_mi_state", dut.u_table.r_mem[2].state, MEORM);
    chk("gets_mi_owner", dut.u_table.r_mem[2].owner, 2);
`else
    chk("gets_mi_state", dut.u_table.r_mem[2].state, MS);
    // MS+GETM takes ownership so the owner-forward path can be exercised.
    push_exp(4'd2, 32'h40, DATA, '0);
    send_req(GETM, 4'd2, 32'h40);
    wait_resp("getm_ms");
    after_resp("getm_ms");
    chk("getm_ms_state", dut.u_table.r_mem[2].state, MEORM);
    chk("getm_ms_owner", dut.u_table.r_mem[2].owner, 2);
`endif

    // GETS to an owned line: no response, waits for owner data
    send_req(GETS, 4'd5, 32'h40);
    repeat (2) begin
      chk("gets_meorm_no_resp", bus_if.resp_o.valid, 0);
      chk("gets_meorm_busy",    bus_if.req_ready_o, 0);
      @(negedge clk);
    end
    chk("gets_meorm_state", dut.u_table.r_mem[2].state, MSD);
    send_wb(DATA, 32'h40, c_AA);
    chk("wb_msd_idle",  bus_if.req_ready_o, 1);
    chk("wb_msd_err",   bus_if.err_o, 0);
    chk("wb_msd_state", dut.u_table.r_mem[2].state, MS);
    chk("wb_msd_data",  dut.u_table.r_mem[2].data, c_AA);

    // MS+GETS returns the written-back data
    push_exp(4'd1, 32'h40, DATA, c_AA);
    send_req(GETS, 4'd1, 32'h40);
    wait_resp("gets_ms");
    after_resp("gets_ms");
    chk("gets_ms_state", dut.u_table.r_mem[2].state, MS);

    // Line 3 -> MEORM owner 3
    push_exp(4'd3, 32'h60, DATA, '0);
    send_req(GETM, 4'd3, 32'h60);
    wait_resp("getm_mi");
    after_resp("getm_mi");

    // Non-owner PUTM gets NODATA; response held under backpressure
    bus_if.resp_ready_i = 1'b0;
    push_exp(4'd4, 32'h60, NODATA, '0);
    send_req(PUTM, 4'd4, 32'h60);
    wait_resp("putm_nonowner");
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid",     bus_if.resp_o.valid, 1);
      chk("stall_dest",      bus_if.resp_o.destination, 4);
      chk("stall_mmsg",      bus_if.resp_o.mmsg, NODATA);
      chk("stall_req_ready", bus_if.req_ready_o, 0);
    end
    bus_if.resp_ready_i = 1'b1;
    after_resp("stall_release");
    chk("putm_nonowner_state", dut.u_table.r_mem[3].state, MEORM);
    chk("putm_nonowner_owner", dut.u_table.r_mem[3].owner, 3);

    // Owner PUTM -> MID; mismatched writeback is flagged and ignored
    send_req(PUTM, 4'd3, 32'h60);
    chk("putm_owner_state", dut.u_table.r_mem[3].state, MID);
    send_wb(DATA, 32'h80, c_55);
    chk("wb_mismatch_err",     bus_if.err_o, 1);
    chk("wb_mismatch_waiting", bus_if.req_ready_o, 0);
    chk("wb_mismatch_line4",   dut.u_table.r_mem[4].data, '0);
    send_wb(NODATAE, 32'h60, c_55);
    chk("wb_nodatae_err",   bus_if.err_o, 0);
    chk("wb_nodatae_idle",  bus_if.req_ready_o, 1);
    chk("wb_nodatae_state", dut.u_table.r_mem[3].state, MI);
    chk("wb_nodatae_data",  dut.u_table.r_mem[3].data, '0);

    // Stale PUTM on an MS line: NODATA with zero data
    push_exp(4'd1, 32'h40, NODATA, '0);
    send_req(PUTM, 4'd1, 32'h40);
    wait_resp("putm_stale");
    after_resp("putm_stale");
    chk("putm_stale_state", dut.u_table.r_mem[2].state, MS);

    // Writeback while idle: one-cycle error, table unchanged
    @(negedge clk);
    send_wb(DATA, 32'h40, c_55);
    chk("wb_idle_err", bus_if.err_o, 1);
    @(negedge clk);
    chk("wb_idle_err_pulse", bus_if.err_o, 0);
    chk("wb_idle_data", dut.u_table.r_mem[2].data, c_AA);

    // MEORM+GETM: ownership moves silently
    push_exp(4'd6, 32'h60, DATA, '0);
    send_req(GETM, 4'd6, 32'h60);
    wait_resp("getm_mi2");
    after_resp("getm_mi2");
    send_req(GETM, 4'd7, 32'h60);
    chk("getm_meorm_no_resp", bus_if.resp_o.valid, 0);
    chk("getm_meorm_idle",    bus_if.req_ready_o, 1);
    chk("getm_meorm_owner",   dut.u_table.r_mem[3].owner, 7);
    chk("getm_meorm_state",   dut.u_table.r_mem[3].state, MEORM);

    // Reset while waiting for a writeback
    send_req(GETS, 4'd8, 32'h60);
    chk("wait_before_rst", bus_if.req_ready_o, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_idle", bus_if.req_ready_o, 1);
    chk("rst_wait_resp", bus_if.resp_o.valid, 0);
    dirty = 0;
    for (int i = 0; i < MEM_LINES; i++) begin
      if (dut.u_table.r_mem[i].state !== MI || dut.u_table.r_mem[i].owner !== '0 ||
          dut.u_table.r_mem[i].data !== '0) begin
        dirty++;
      end
    end
    chk("rst_wait_table_clean", dirty, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
